// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: groups the character, pop, flush and status signals of the
// UART receive FIFO.
//   master : deserializer / register side, which drives writes, pops and clears
//   slave  : the FIFO, which drives the head entry, status flags and fill count
interface uart_rx_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_parity_err;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_parity_err;
    logic                  fifo_clr;
    logic [1:0]            sticky_clr;
    logic                  rx_full_status;
    logic                  rx_empty_status;
    logic                  parrity_error_status;
    logic                  overrun_status;
    logic [ADDR_WIDTH:0]   fifo_count;

    modport master (
        output wr_en, wr_data, wr_parity_err, rd_en, fifo_clr, sticky_clr,
        input  rd_data, rd_parity_err, rx_full_status, rx_empty_status,
               parrity_error_status, overrun_status, fifo_count
    );

    modport slave (
        input  wr_en, wr_data, wr_parity_err, rd_en, fifo_clr, sticky_clr,
        output rd_data, rd_parity_err, rx_full_status, rx_empty_status,
               parrity_error_status, overrun_status, fifo_count
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side character buffer with per-entry parity flag.
// Show-ahead read port, level flags decoded from the registered count, and
// write-1-to-clear sticky parity / overrun flags.
//   clk  : single clock
//   rst  : synchronous, active-high reset
//   bus  : uart_rx_fifo_if.slave (writes, pops, flush, sticky clear, status)
module uart_rx_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input logic           clk,
    input logic           rst,
    uart_rx_fifo_if.slave bus
);
    localparam int unsigned         EntryWidth = DATA_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] FullCount  = (ADDR_WIDTH + 1)'(DEPTH);

    // Each entry is {parity_err, data}.
    logic [EntryWidth-1:0] mem_q [DEPTH];
    logic [EntryWidth-1:0] head;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  par_sticky_q, par_sticky_d;
    logic                  ovr_sticky_q, ovr_sticky_d;

    logic full, empty;
    logic wr_accept, rd_accept, wr_drop;

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);

    // Acceptance uses the pre-edge count; a flush suppresses all traffic.
    assign wr_accept = bus.wr_en && !full  && !bus.fifo_clr;
    assign rd_accept = bus.rd_en && !empty && !bus.fifo_clr;
    assign wr_drop   = bus.wr_en && full   && !bus.fifo_clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.fifo_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_accept) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (rd_accept) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            unique case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
                2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
                default: count_d = count_q;
            endcase
        end
        // Set beats a coincident clear.
        par_sticky_d = (wr_accept && bus.wr_parity_err) ||
                       (par_sticky_q && !bus.sticky_clr[0]);
        ovr_sticky_d = wr_drop || (ovr_sticky_q && !bus.sticky_clr[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            par_sticky_q <= 1'b0;
            ovr_sticky_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            par_sticky_q <= par_sticky_d;
            ovr_sticky_q <= ovr_sticky_d;
        end
    end

    // Storage is not reset; an empty FIFO masks the head to zero.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem_q[wr_ptr_q] <= {bus.wr_parity_err, bus.wr_data};
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign bus.rd_data              = empty ? '0 : head[DATA_WIDTH-1:0];
    assign bus.rd_parity_err        = empty ? 1'b0 : head[DATA_WIDTH];
    assign bus.rx_full_status       = full;
    assign bus.rx_empty_status      = empty;
    assign bus.parrity_error_status = par_sticky_q;
    assign bus.overrun_status       = ovr_sticky_q;
    assign bus.fifo_count           = count_q;
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer between the UART RX deserializer and the AHB register/interrupt logic. Stores received characters, each tagged with its parity-error flag. Produces the level and sticky status flags consumed by the interrupt masking stage: rx_full_status, rx_empty_status and parrity_error_status. Also reports an overrun condition and a fill count for the register map.

Parameters:
DATA_WIDTH, 8, width of one received character
DEPTH, 16, number of entries; power of two, minimum 2
ADDR_WIDTH, 4, log2(DEPTH); must be consistent with DEPTH

Ports:
clk  input  1  single clock for all state
rst  input  1  synchronous reset, active-high
wr_en  input  1  deserializer pushes one character this cycle
wr_data  input  DATA_WIDTH  received character
wr_parity_err  input  1  parity error flag for wr_data
rd_en  input  1  register-read pop request (one-cycle pulse per pop)
rd_data  output  DATA_WIDTH  head-of-FIFO character (show-ahead)
rd_parity_err  output  1  parity flag of the head entry
fifo_clr  input  1  flush pointers and count; sticky flags unaffected
sticky_clr  input  2  write-1-to-clear: bit0 = parity sticky, bit1 = overrun sticky
rx_full_status  output  1  count == DEPTH
rx_empty_status  output  1  count == 0
parrity_error_status  output  1  sticky: an accepted entry carried a parity error
overrun_status  output  1  sticky: a write was dropped because the FIFO was full
fifo_count  output  ADDR_WIDTH+1  number of stored entries, 0..DEPTH

Behaviour:
- Reset (rst=1 at a clk edge): wr_ptr=0, rd_ptr=0, count=0. Both stickies are 0. rx_empty_status=1, rx_full_status=0. rd_data=0, rd_parity_err=0, fifo_count=0. Memory contents are don't-care.
- Storage: DEPTH x (DATA_WIDTH+1) array holding {parity_err, data}. Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- Write acceptance: wr_en=1 and count<DEPTH. Data is stored at wr_ptr and wr_ptr increments on that edge.
- Read acceptance: rd_en=1 and count>0. rd_ptr increments on that edge.
- Simultaneous accepted read and write: count is unchanged and both pointers advance.
- Full + wr_en + rd_en: the read is accepted and the write is dropped, because acceptance is evaluated on pre-edge count. overrun_status sets.
- Full + wr_en, no rd_en: the write is dropped, overrun_status sets, and FIFO contents are untouched.
- Empty + rd_en: ignored, with no pointer change and no error.
- Empty + wr_en + rd_en: only the write is accepted, and count becomes 1.
- Show-ahead read port:
  - rd_data and rd_parity_err are combinational from mem[rd_ptr] when count>0, and 0 when count==0.
  - A written entry is visible on rd_data the cycle after its write edge.
  - After a pop, the next entry appears the cycle after the rd_en edge.
- Status flags are combinational decodes of the registered count: rx_full_status=(count==DEPTH), rx_empty_status=(count==0). fifo_count=count. There is no extra latency beyond the count register.
- parrity_error_status sets on the edge where a write is accepted with wr_parity_err=1. A dropped write never sets it.
- Sticky clear: sticky_clr[0] clears parrity_error_status and sticky_clr[1] clears overrun_status.
  - If set and clear coincide on the same edge, set wins and the flag stays 1.
- fifo_clr=1: on that edge wr_ptr=rd_ptr=0 and count=0.
  - Any wr_en or rd_en in the same cycle is ignored.
  - Stickies are unaffected, except that sticky_clr in the same cycle is still honoured.
- Priority on an edge: rst > fifo_clr > normal read/write.
- Reset or fifo_clr mid-stream discards all stored entries. The block has no partial-state recovery.
- The block does not mask or generate interrupts. Masking is done downstream.

Test Plan:
- Reset then idle -> rx_empty_status=1, rx_full_status=0, fifo_count=0, rd_data=0x00, both stickies 0.
- Write 0x41,0x42,0x43 (no parity err), then pop 3 times -> rd_data shows 0x41, 0x42, 0x43 in order, fifo_count 3→0, rx_empty_status returns to 1.
- Write 16 entries 0x00..0x0F, then a 17th write 0xFF -> rx_full_status=1, overrun_status=1, 0xFF not stored; popping all 16 returns 0x00..0x0F. Then 20 more write/pop pairs verify pointer wrap with correct data.
- Write 0x55 with wr_parity_err=1 -> parrity_error_status=1 next cycle and rd_parity_err=1 at head. Pulse sticky_clr=2'b01 alone -> flag 0. Repeat with the clear coincident with a new erroneous write -> flag stays 1.
- Full FIFO with wr_en=1 and rd_en=1 in the same cycle -> fifo_count goes 16→15, overrun_status=1, head advances. Empty FIFO with both asserted -> fifo_count=1, rd_data=written value.
- Load 5 entries and set the parity sticky, then assert fifo_clr -> fifo_count=0, rx_empty_status=1, parrity_error_status still 1. Assert rst mid-stream -> all outputs return to reset values.
